larpix_primary_uart: RTL and testbench



---
 rtl/larpix_uart_pkg.sv | 27 ++
 rtl/larpix_uart_rx_deser.sv | 127 ++++++++++++
 rtl/larpix_primary_uart.sv | 128 ++++++++++++
 tb/tb_larpix_primary_uart.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/larpix_uart_pkg.sv
// Shared types for the LArPix primary UART: packet width, TX/RX state encodings,
// and the odd-parity helper used by the LARPIX_UART_PARITY_EN build.
package larpix_uart_pkg;

  localparam int PACKET_WIDTH = 64;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  // Value of packet bit 63 that makes the whole 64-bit word have odd parity.
  function automatic logic odd_parity(input logic [PACKET_WIDTH-2:0] bits);
    return ~^bits;
  endfunction

endpackage

// File: rtl/larpix_uart_rx_deser.sv
// PISO deserializer: 2-flop synchronizer, mid-bit sampling RX FSM, LSB-first shifter.
// Parity checking is compiled in with LARPIX_UART_PARITY_EN.
module larpix_uart_rx_deser
  import larpix_uart_pkg::*;
#(
  parameter int WIDTH        = PACKET_WIDTH,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_piso,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_frame_err,
  output logic             o_parity_err,
  output logic [2:0]       o_state
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             r_sync1, r_sync2;
  rx_state_t        r_state, w_state_nxt;
  logic [CW-1:0]    r_baud, w_baud_nxt;
  logic [BW-1:0]    r_bit, w_bit_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [WIDTH-1:0] r_data, w_data_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_ferr, w_ferr_nxt;
  logic             r_perr, w_perr_nxt;
  logic             w_rx, w_baud_end, w_mid_start, w_parity_bad;

  assign w_rx        = r_sync2;
  assign w_baud_end  = (r_baud == CW'(CLKS_PER_BIT - 1));
  assign w_mid_start = (r_baud == CW'(CLKS_PER_BIT / 2 - 1));

`ifdef LARPIX_UART_PARITY_EN
  assign w_parity_bad = ~(^r_shift);
`else
  assign w_parity_bad = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_state <= RX_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_perr  <= 1'b0;
    end else begin
      r_sync1 <= i_piso;
      r_sync2 <= r_sync1;
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_ferr  <= w_ferr_nxt;
      r_perr  <= w_perr_nxt;
    end
  end

  // START waits half a bit so every later sample lands mid-bit.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud + 1'b1;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;
    w_perr_nxt  = 1'b0;
    case (r_state)
      RX_IDLE: begin
        w_baud_nxt = '0;
        if (!w_rx) w_state_nxt = RX_START;
      end
      RX_START: begin
        if (w_mid_start) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = w_rx ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (w_baud_end) begin
          w_baud_nxt  = '0;
          w_shift_nxt = {w_rx, r_shift[WIDTH-1:1]};
          if (r_bit == BW'(WIDTH - 1)) w_state_nxt = RX_STOP;
          else                         w_bit_nxt   = r_bit + 1'b1;
        end
      end
      RX_STOP: begin
        if (w_baud_end) begin
          w_baud_nxt = '0;
          if (w_rx) begin
            w_data_nxt  = r_shift;
            w_valid_nxt = 1'b1;
            w_perr_nxt  = w_parity_bad;
            w_state_nxt = RX_IDLE;
          end else begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = RX_BREAK;
          end
        end
      end
      RX_BREAK: begin
        w_baud_nxt = '0;
        if (w_rx) w_state_nxt = RX_IDLE;
      end
      default: w_state_nxt = RX_IDLE;
    endcase
  end

  assign o_data       = r_data;
  assign o_valid      = r_valid;
  assign o_frame_err  = r_ferr;
  assign o_parity_err = r_perr;
  assign o_state      = r_state;

endmodule

// File: rtl/larpix_primary_uart.sv
// Host-side LArPix UART channel: inline POSI serializer plus the PISO deserializer.
// Define LARPIX_UART_PARITY_EN to force odd parity into bit WIDTH-1 and check it on RX.
module larpix_primary_uart
  import larpix_uart_pkg::*;
#(
  parameter int WIDTH        = PACKET_WIDTH,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             posi,
  input  logic             piso,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             rx_frame_err,
  output logic             rx_parity_err,
  output logic             tx_busy,
  output logic [1:0]       tx_state_dbg,
  output logic [2:0]       rx_state_dbg
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  tx_state_t        r_tx_state, w_tx_state_nxt;
  logic [CW-1:0]    r_tx_baud, w_tx_baud_nxt;
  logic [BW-1:0]    r_tx_bit, w_tx_bit_nxt;
  logic [WIDTH-1:0] r_tx_shift, w_tx_shift_nxt, w_tx_load;
  logic             r_posi, w_posi_nxt;
  logic             w_tx_accept, w_tx_baud_end;

  // Handshake: a packet is taken at a clk edge where tx_valid && tx_ready; there is
  // no queue, so tx_valid while tx_ready=0 is simply ignored.
  assign tx_ready      = (r_tx_state == TX_IDLE) && !reset;
  assign w_tx_accept   = tx_valid && tx_ready;
  assign w_tx_baud_end = (r_tx_baud == CW'(CLKS_PER_BIT - 1));
  assign tx_busy       = (r_tx_state != TX_IDLE);

`ifdef LARPIX_UART_PARITY_EN
  assign w_tx_load = {odd_parity(tx_data[WIDTH-2:0]), tx_data[WIDTH-2:0]};
`else
  assign w_tx_load = tx_data;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_baud  <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_posi     <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_baud  <= w_tx_baud_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_posi     <= w_posi_nxt;
    end
  end

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_baud_nxt  = r_tx_baud + 1'b1;
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_shift_nxt = r_tx_shift;
    case (r_tx_state)
      TX_IDLE: begin
        w_tx_baud_nxt = '0;
        if (w_tx_accept) begin
          w_tx_shift_nxt = w_tx_load;
          w_tx_state_nxt = TX_START;
        end
      end
      TX_START: begin
        if (w_tx_baud_end) begin
          w_tx_baud_nxt  = '0;
          w_tx_bit_nxt   = '0;
          w_tx_state_nxt = TX_DATA;
        end
      end
      TX_DATA: begin
        if (w_tx_baud_end) begin
          w_tx_baud_nxt  = '0;
          w_tx_shift_nxt = {1'b0, r_tx_shift[WIDTH-1:1]};
          if (r_tx_bit == BW'(WIDTH - 1)) w_tx_state_nxt = TX_STOP;
          else                            w_tx_bit_nxt   = r_tx_bit + 1'b1;
        end
      end
      TX_STOP: begin
        if (w_tx_baud_end) begin
          w_tx_baud_nxt  = '0;
          w_tx_state_nxt = TX_IDLE;
        end
      end
      default: w_tx_state_nxt = TX_IDLE;
    endcase
  end

  // The line level is registered from the next state so posi never glitches.
  always_comb begin
    case (w_tx_state_nxt)
      TX_START: w_posi_nxt = 1'b0;
      TX_DATA:  w_posi_nxt = w_tx_shift_nxt[0];
      default:  w_posi_nxt = 1'b1;
    endcase
  end

  assign posi         = r_posi;
  assign tx_state_dbg = r_tx_state;

  larpix_uart_rx_deser #(
    .WIDTH        (WIDTH),
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_piso       (piso),
    .o_data       (rx_data),
    .o_valid      (rx_valid),
    .o_frame_err  (rx_frame_err),
    .o_parity_err (rx_parity_err),
    .o_state      (rx_state_dbg)
  );

endmodule

// File: tb/tb_larpix_primary_uart.sv
// Directed bench for larpix_primary_uart: loopback, back-to-back, glitch, frame error,
// mid-frame reset and parity (expectations switch on LARPIX_UART_PARITY_EN).
module tb_larpix_primary_uart;

  localparam int W   = 64;
  localparam int CPB = 4;
  localparam logic [2:0] RXS_IDLE  = 3'd0;
  localparam logic [2:0] RXS_BREAK = 3'd4;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0] tx_data;
  logic         tx_valid;
  logic         tx_ready, posi, piso, tx_busy;
  logic [W-1:0] rx_data;
  logic         rx_valid, rx_frame_err, rx_parity_err;
  logic [1:0]   tx_state_dbg;
  logic [2:0]   rx_state_dbg;
  logic         loop_en = 1'b0;
  logic         piso_drv = 1'b1;

  assign piso = loop_en ? posi : piso_drv;

  larpix_primary_uart #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
    .clk           (clk),
    .reset         (reset),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .posi          (posi),
    .piso          (piso),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_frame_err  (rx_frame_err),
    .rx_parity_err (rx_parity_err),
    .tx_busy       (tx_busy),
    .tx_state_dbg  (tx_state_dbg),
    .rx_state_dbg  (rx_state_dbg)
  );

  int total = 0;
  int bad   = 0;
  int n_valid = 0;
  int n_ferr  = 0;
  int n_perr  = 0;
  logic [W-1:0] exp_q[$];
  logic         exp_perr_q[$];

`ifdef LARPIX_UART_PARITY_EN
  localparam logic PAR_ON = 1'b1;
`else
  localparam logic PAR_ON = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Packet as it appears on the wire for a given tx_data.
  function automatic logic [63:0] wire_word(input logic [63:0] d);
    logic [63:0] r;
    r = d;
    if (PAR_ON) r[63] = ~^d[62:0];
    return r;
  endfunction

  // scoreboard
  always @(negedge clk) begin
    if (rx_frame_err)  n_ferr++;
    if (rx_parity_err) n_perr++;
    if (rx_valid) begin
      n_valid++;
      check("rx_valid_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        check("rx_data", rx_data, exp_q.pop_front());
        check("rx_parity_err_at_valid", 64'(rx_parity_err), 64'(exp_perr_q.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_raw(input logic [63:0] d, input logic stop_b);
    piso_drv = 1'b0;
    tick(CPB);
    for (int i = 0; i < W; i++) begin
      piso_drv = d[i];
      tick(CPB);
    end
    piso_drv = stop_b;
    tick(CPB);
  endtask

  // Loopback send from idle; checks tx_ready/rx_valid latency and wire bit 63.
  task automatic send_timed(input logic [63:0] d, input string tag);
    int ready_at;
    int valid_at;
    logic b63;
    logic [63:0] ww;
    ready_at = 0;
    valid_at = 0;
    b63 = 1'bx;
    ww = wire_word(d);
    exp_q.push_back(ww);
    exp_perr_q.push_back(1'b0);
    tx_data  = d;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    tx_data  = ~d;
    check({tag, "_posi_start"}, 64'(posi), 64'd0);
    check({tag, "_busy"}, 64'(tx_busy), 64'd1);
    for (int k = 1; k <= 400 && valid_at == 0; k++) begin
      tick(1);
      if (k == 258) b63 = posi;
      if (ready_at == 0 && tx_ready) ready_at = k;
      if (rx_valid) valid_at = k;
    end
    check({tag, "_ready_latency"}, 64'(ready_at), 64'd264);
    check({tag, "_valid_latency"}, 64'(valid_at), 64'd265);
    check({tag, "_wire_bit63"}, 64'(b63), 64'(ww[63]));
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int base_v, base_f, acc2, v1, v2;
    logic prev_ready;
    tx_data  = '0;
    tx_valid = 1'b0;
    reset    = 1'b1;
    tick(3);
    check("rst_posi", 64'(posi), 64'd1);
    check("rst_tx_ready", 64'(tx_ready), 64'd0);
    check("rst_tx_busy", 64'(tx_busy), 64'd0);
    check("rst_rx_data", rx_data, 64'd0);
    check("rst_rx_valid", 64'(rx_valid), 64'd0);
    check("rst_rx_frame_err", 64'(rx_frame_err), 64'd0);
    check("rst_rx_parity_err", 64'(rx_parity_err), 64'd0);
    check("rst_rx_state", 64'(rx_state_dbg), 64'(RXS_IDLE));
    reset = 1'b0;
    #1;
    check("ready_after_release", 64'(tx_ready), 64'd1);
    tick(2);

    // loopback
    loop_en = 1'b1;
    send_timed(64'h0123_4567_89AB_CDEF, "loop1");
    tick(3);

    // back-to-back with tx_valid held
    exp_q.push_back(wire_word(64'hFFFF_FFFF_FFFF_FFFF));
    exp_perr_q.push_back(1'b0);
    exp_q.push_back(wire_word(64'h0));
    exp_perr_q.push_back(1'b0);
    tx_data  = 64'hFFFF_FFFF_FFFF_FFFF;
    tx_valid = 1'b1;
    tick(1);
    tx_data = 64'h0;
    acc2 = 0; v1 = 0; v2 = 0;
    for (int k = 1; k <= 700 && v2 == 0; k++) begin
      prev_ready = tx_ready;
      tick(1);
      if (acc2 == 0 && prev_ready && tx_busy) begin
        acc2 = k;
        tx_valid = 1'b0;
      end
      if (rx_valid) begin
        if (v1 == 0) v1 = k;
        else         v2 = k;
      end
    end
    check("b2b_second_accept", 64'(acc2), 64'd265);
    check("b2b_first_valid", 64'(v1), 64'd265);
    check("b2b_valid_spacing", 64'(v2 - v1), 64'd265);
    tick(4);

    // one-cycle glitch on piso
    loop_en  = 1'b0;
    piso_drv = 1'b1;
    tick(4);
    base_v = n_valid;
    base_f = n_ferr;
    piso_drv = 1'b0;
    tick(1);
    piso_drv = 1'b1;
    tick(10);
    check("glitch_rx_state", 64'(rx_state_dbg), 64'(RXS_IDLE));
    check("glitch_no_valid", 64'(n_valid - base_v), 64'd0);
    check("glitch_no_ferr", 64'(n_ferr - base_f), 64'd0);

    // frame with stop bit 0, line held low into a break
    send_raw(64'h1357_9BDF_2468_ACE0, 1'b0);
    tick(8);
    check("ferr_count", 64'(n_ferr - base_f), 64'd1);
    check("ferr_no_valid", 64'(n_valid - base_v), 64'd0);
    check("ferr_rx_data_kept", rx_data, wire_word(64'h0));
    check("ferr_in_break", 64'(rx_state_dbg), 64'(RXS_BREAK));
    piso_drv = 1'b1;
    tick(4);
    check("break_exit_idle", 64'(rx_state_dbg), 64'(RXS_IDLE));
    exp_q.push_back(64'hA5A5_5A5A_0F0F_F0F1);
    exp_perr_q.push_back(1'b0);
    send_raw(64'hA5A5_5A5A_0F0F_F0F1, 1'b1);
    tick(6);
    check("after_break_valid", 64'(n_valid - base_v), 64'd1);

    // frame with bit 5 flipped from a good-parity zero packet
    exp_q.push_back(64'h8000_0000_0000_0020);
    exp_perr_q.push_back(PAR_ON);
    send_raw(64'h8000_0000_0000_0020, 1'b1);
    tick(6);
    check("flip_valid", 64'(n_valid - base_v), 64'd2);
    check("flip_perr_count", 64'(n_perr), 64'(PAR_ON));

    // reset in the middle of a looped-back frame (TX bit 30)
    loop_en  = 1'b1;
    tick(2);
    base_v = n_valid;
    base_f = n_ferr;
    tx_data  = 64'hCAFE_0000_1234_5678;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    tick(125);
    check("midframe_busy", 64'(tx_busy), 64'd1);
    reset = 1'b1;
    tick(1);
    check("midrst_posi", 64'(posi), 64'd1);
    check("midrst_tx_busy", 64'(tx_busy), 64'd0);
    check("midrst_rx_state", 64'(rx_state_dbg), 64'(RXS_IDLE));
    reset = 1'b0;
    tick(300);
    check("midrst_no_valid", 64'(n_valid - base_v), 64'd0);
    check("midrst_no_ferr", 64'(n_ferr - base_f), 64'd0);
    send_timed(64'hDEAD_BEEF_CAFE_F00D, "post_rst");
    tick(3);

    // zero packet: bit 63 on the wire carries parity only in the parity build
    send_timed(64'h0, "zero");
    tick(10);

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    check("final_perr_total", 64'(n_perr), 64'(PAR_ON));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
